sr_stream_fifo: RTL and testbench
=================================

# sr_stream_fifo

Parametrised synchronous stream FIFO, the successor to the core's single-port-at-a-time FIFO. Accepts a push and a pop in the same cycle, exposes an occupancy count, almost-full/almost-empty thresholds and sticky error flags, and offers a registered-read or first-word-fall-through (FWFT) read mode. It buffers data between the schoolRISCV core and its peripherals (UART, debug, MMIO streams).

## Interface
- DATA_WIDTH, 32: width of one entry
- ADDR_WIDTH, 3: pointer width; DEPTH = 2**ADDR_WIDTH entries (ADDR_WIDTH ≥ 1)
- FWFT, 0: 0 = registered read, 1 = first-word-fall-through
- AF_LEVEL, DEPTH-1: almost_full asserted when count ≥ AF_LEVEL
- AE_LEVEL, 1: almost_empty asserted when count ≤ AE_LEVEL
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- clear  in  1  synchronous flush, priority over push/pop
- wr_valid  in  1  push request
- wr_data  in  DATA_WIDTH  push data
- wr_ready  out  1  = !full
- rd_ready  in  1  pop request (FWFT=0) / consumer ready (FWFT=1)
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  read data
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- almost_full, almost_empty  out  1  threshold flags
- overflow, underflow  out  1  sticky error flags

## Operation
- push = wr_valid && wr_ready; pop = rd_ready && !empty (FWFT=0), rd_valid && rd_ready (FWFT=1).
- push writes mem[wr_ptr], wr_ptr+1 mod DEPTH; pop reads mem[rd_ptr], rd_ptr+1 mod DEPTH; pointers wrap naturally at ADDR_WIDTH bits.
- count: +1 push only, −1 pop only, unchanged on push+pop or neither. full = (count==DEPTH), empty = (count==0).
- Push and pop in the same cycle are both accepted whenever individually legal. Full: push refused even with concurrent pop (no pass-through). Empty: pop refused even with concurrent push.
- FWFT=0: rd_data registered, loaded on pop, otherwise held; rd_valid is a 1-cycle pulse the cycle after each pop.
- FWFT=1: rd_valid = !empty; rd_data = mem[rd_ptr] (asynchronous read of head).
- overflow set when wr_valid && !wr_ready; underflow set when rd_ready && empty with FWFT=0 (never set in FWFT=1). Both hold until clear or reset.
- clear: pointers, count, rd_valid, overflow, underflow → 0; rd_data (FWFT=0) holds; memory contents not cleared; push/pop in that cycle ignored.
- Flags and wr_ready derived combinationally from count.

## Timing
- Reset values: count 0, wr_ready 1, rd_valid 0, rd_data 0, almost_full 0 (AF_LEVEL ≥ 1), almost_empty 1, overflow 0, underflow 0.
- Reset asserted mid-operation: state returns to reset values immediately, asynchronously; stored data discarded.
- Write-to-read latency: FWFT=1, push at edge N → rd_valid high after edge N. FWFT=0, pop at edge N → rd_data/rd_valid valid after edge N.
- count/flags update at the same edge as the push/pop.
- Full throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.

## Structure
- Shared header sr_fifo_defs.vh: mode constants SR_FIFO_REGISTERED=0, SR_FIFO_FWFT=1; reused by the future dual-clock FIFO.
- Sub-module sr_fifo_mem: DEPTH×DATA_WIDTH register array, one synchronous write port, one asynchronous read port; no reset on storage.
- Top: pointers, counter, flags, output register, error flags.

## Test plan
- Reset, DEPTH=8, FWFT=0: push 0x11..0x88 → count 8, wr_ready 0, almost_full 1; 8 pops → rd_data 0x11..0x88 in order, count 0, almost_empty 1.
- Full FIFO, wr_valid=1 with rd_ready=1 → pop accepted, push refused, count 7, overflow 1 and sticky; clear → overflow 0, count 0.
- FWFT=1, empty: push 0xA5 → next cycle rd_valid 1, rd_data 0xA5; rd_ready=1 → rd_valid 0 after edge.
- Count 3, push+pop every cycle for 20 cycles → count stays 3, data order preserved across pointer wrap.
- FWFT=0 empty, rd_ready=1 → no rd_valid pulse, underflow 1, count 0.
- Count 5, assert reset mid-stream between edges → all outputs at reset values immediately; post-reset push 0x42 then pop returns 0x42.

Source files
------------

// File: rtl/sr_stream_fifo_pkg.sv
// Shared FIFO mode constants and sizing helper, reused by the stream FIFO
// family (single-clock now, dual-clock later).
package sr_stream_fifo_pkg;

  localparam int SR_FIFO_REGISTERED = 0;
  localparam int SR_FIFO_FWFT       = 1;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sr_stream_fifo_if.sv
// Write/read handshake and status bundle of the stream FIFO.
// slave = FIFO side, master = producer/consumer side.
interface sr_stream_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count,
           almost_full, almost_empty, overflow, underflow
  );

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sr_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, synchronous write, asynchronous read.
// No reset on the array; contents are only meaningful between the pointers.
module sr_fifo_mem
  import sr_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sr_stream_fifo.sv
// Synchronous stream FIFO with simultaneous push/pop, occupancy count,
// threshold flags, sticky error flags and registered or FWFT read mode.
module sr_stream_fifo
  import sr_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = SR_FIFO_REGISTERED,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic             clk,
  input logic             reset,
  input logic             clear,
  sr_stream_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   AF_C     = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C     = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] head;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign push  = bus.wr_valid && !full && !clear;
  // In FWFT mode rd_valid == !empty, so both modes reduce to the same pop term.
  assign pop   = bus.rd_ready && !empty && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.wr_valid && full);
    udf_d    = udf_q | ((FWFT == SR_FIFO_REGISTERED) && bus.rd_ready && empty);
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sr_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  if (FWFT == SR_FIFO_FWFT) begin : g_fwft
    assign bus.rd_valid = !empty;
    assign bus.rd_data  = head;
  end else begin : g_reg
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // rd_data survives clear; only reset zeroes it.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else if (clear) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop;
        if (pop) rd_data_q <= head;
      end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
  end

  assign bus.count        = count_q;
  assign bus.wr_ready     = !full;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sr_stream_fifo.sv
// Scoreboard bench for sr_stream_fifo: one registered-read and one FWFT instance.
module tb_sr_stream_fifo;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear0 = 1'b0;
  logic clear1 = 1'b0;
  int   passed = 0;
  int   total = 0;
  logic [DW-1:0] sb0 [$];
  logic [DW-1:0] sb1 [$];
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  sr_stream_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  sr_stream_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  sr_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_LEVEL(7), .AE_LEVEL(1))
    dut0 (.clk(clk), .reset(reset), .clear(clear0), .bus(if0));
  sr_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_LEVEL(7), .AE_LEVEL(1))
    dut1 (.clk(clk), .reset(reset), .clear(clear1), .bus(if1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input int n, input logic [DW-1:0] base, input logic [DW-1:0] inc);
    for (int i = 0; i < n; i++) begin
      if0.wr_valid = 1'b1;
      if0.wr_data  = base + inc * DW'(i);
      sb0.push_back(if0.wr_data);
      step();
    end
    if0.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (if0.count !== 4'd0) $display("FAIL rst_count got %0d exp 0", if0.count); else passed++;
    total++; if (if0.wr_ready !== 1'b1) $display("FAIL rst_wr_ready got %b exp 1", if0.wr_ready); else passed++;
    total++; if (if0.rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %b exp 0", if0.rd_valid); else passed++;
    total++; if (if0.rd_data !== '0) $display("FAIL rst_rd_data got %h exp 0", if0.rd_data); else passed++;
    total++; if (if0.almost_full !== 1'b0) $display("FAIL rst_af got %b exp 0", if0.almost_full); else passed++;
    total++; if (if0.almost_empty !== 1'b1) $display("FAIL rst_ae got %b exp 1", if0.almost_empty); else passed++;
    total++; if ({if0.overflow, if0.underflow} !== 2'b00) $display("FAIL rst_err got %b exp 00", {if0.overflow, if0.underflow}); else passed++;
    total++; if (if1.rd_valid !== 1'b0) $display("FAIL rst_fwft_rd_valid got %b exp 0", if1.rd_valid); else passed++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      if0.wr_valid = 1'b1;
      if0.wr_data  = DW'(8'h11 * (i + 1));
      sb0.push_back(if0.wr_data);
      step();
      total++; if (if0.almost_full !== (i + 1 >= 7)) $display("FAIL fill_af n=%0d got %b", i + 1, if0.almost_full); else passed++;
      total++; if (if0.almost_empty !== (i + 1 <= 1)) $display("FAIL fill_ae n=%0d got %b", i + 1, if0.almost_empty); else passed++;
    end
    if0.wr_valid = 1'b0;
    total++; if (if0.count !== 4'd8) $display("FAIL fill_count got %0d exp 8", if0.count); else passed++;
    total++; if (if0.wr_ready !== 1'b0) $display("FAIL fill_wr_ready got %b exp 0", if0.wr_ready); else passed++;
    if0.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_d = sb0.pop_front();
      total++; if (if0.rd_valid !== 1'b1) $display("FAIL drain_valid i=%0d got %b exp 1", i, if0.rd_valid); else passed++;
      total++; if (if0.rd_data !== exp_d) $display("FAIL drain_data i=%0d got %h exp %h", i, if0.rd_data, exp_d); else passed++;
    end
    if0.rd_ready = 1'b0;
    total++; if (if0.count !== 4'd0) $display("FAIL drain_count got %0d exp 0", if0.count); else passed++;
    total++; if (if0.almost_empty !== 1'b1) $display("FAIL drain_ae got %b exp 1", if0.almost_empty); else passed++;
    total++; if (if0.underflow !== 1'b0) $display("FAIL drain_udf got %b exp 0", if0.underflow); else passed++;
    step();
    total++; if (if0.rd_valid !== 1'b0) $display("FAIL drain_pulse got %b exp 0", if0.rd_valid); else passed++;
  endtask

  task automatic test_overflow();
    push0(8, 32'hA0, 32'h1);
    if0.wr_valid = 1'b1;
    if0.wr_data  = 32'hDEAD;
    if0.rd_ready = 1'b1;
    step();
    if0.wr_valid = 1'b0;
    if0.rd_ready = 1'b0;
    exp_d = sb0.pop_front();
    total++; if (if0.rd_data !== exp_d) $display("FAIL ovf_pop_data got %h exp %h", if0.rd_data, exp_d); else passed++;
    total++; if (if0.count !== 4'd7) $display("FAIL ovf_count got %0d exp 7", if0.count); else passed++;
    total++; if (if0.overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", if0.overflow); else passed++;
    step();
    total++; if (if0.overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", if0.overflow); else passed++;
    clear0 = 1'b1;
    step();
    clear0 = 1'b0;
    sb0.delete();
    total++; if (if0.overflow !== 1'b0) $display("FAIL clr_ovf got %b exp 0", if0.overflow); else passed++;
    total++; if (if0.count !== 4'd0) $display("FAIL clr_count got %0d exp 0", if0.count); else passed++;
    total++; if (if0.rd_data !== exp_d) $display("FAIL clr_rd_data_hold got %h exp %h", if0.rd_data, exp_d); else passed++;
  endtask

  task automatic test_fwft();
    if1.wr_valid = 1'b1;
    if1.wr_data  = 32'hA5;
    sb1.push_back(if1.wr_data);
    step();
    if1.wr_valid = 1'b0;
    exp_d = sb1.pop_front();
    total++; if (if1.rd_valid !== 1'b1) $display("FAIL fwft_valid got %b exp 1", if1.rd_valid); else passed++;
    total++; if (if1.rd_data !== exp_d) $display("FAIL fwft_data got %h exp %h", if1.rd_data, exp_d); else passed++;
    if1.rd_ready = 1'b1;
    step();
    total++; if (if1.rd_valid !== 1'b0) $display("FAIL fwft_pop_valid got %b exp 0", if1.rd_valid); else passed++;
    total++; if (if1.count !== 4'd0) $display("FAIL fwft_pop_count got %0d exp 0", if1.count); else passed++;
    step();
    if1.rd_ready = 1'b0;
    total++; if (if1.underflow !== 1'b0) $display("FAIL fwft_udf got %b exp 0", if1.underflow); else passed++;
  endtask

  task automatic test_back_to_back();
    push0(3, 32'h100, 32'h1);
    for (int k = 0; k < 20; k++) begin
      if0.wr_valid = 1'b1;
      if0.wr_data  = 32'h200 + DW'(k);
      if0.rd_ready = 1'b1;
      sb0.push_back(if0.wr_data);
      step();
      exp_d = sb0.pop_front();
      total++; if (if0.rd_data !== exp_d || if0.rd_valid !== 1'b1) $display("FAIL b2b_data k=%0d got %h/%b exp %h/1", k, if0.rd_data, if0.rd_valid, exp_d); else passed++;
      total++; if (if0.count !== 4'd3) $display("FAIL b2b_count k=%0d got %0d exp 3", k, if0.count); else passed++;
    end
    if0.wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_d = sb0.pop_front();
      total++; if (if0.rd_data !== exp_d) $display("FAIL b2b_tail i=%0d got %h exp %h", i, if0.rd_data, exp_d); else passed++;
    end
    if0.rd_ready = 1'b0;
    step();
  endtask

  task automatic test_underflow();
    if0.rd_ready = 1'b1;
    step();
    if0.rd_ready = 1'b0;
    total++; if (if0.rd_valid !== 1'b0) $display("FAIL udf_valid got %b exp 0", if0.rd_valid); else passed++;
    total++; if (if0.underflow !== 1'b1) $display("FAIL udf_set got %b exp 1", if0.underflow); else passed++;
    total++; if (if0.count !== 4'd0) $display("FAIL udf_count got %0d exp 0", if0.count); else passed++;
    step();
    total++; if (if0.underflow !== 1'b1) $display("FAIL udf_sticky got %b exp 1", if0.underflow); else passed++;
  endtask

  task automatic test_reset_mid();
    push0(5, 32'h31, 32'h1);
    total++; if (if0.count !== 4'd5) $display("FAIL mid_pre_count got %0d exp 5", if0.count); else passed++;
    #2;
    reset = 1'b0;
    #1;
    sb0.delete();
    total++; if (if0.count !== 4'd0) $display("FAIL mid_count got %0d exp 0", if0.count); else passed++;
    total++; if (if0.wr_ready !== 1'b1) $display("FAIL mid_wr_ready got %b exp 1", if0.wr_ready); else passed++;
    total++; if (if0.rd_data !== '0) $display("FAIL mid_rd_data got %h exp 0", if0.rd_data); else passed++;
    total++; if ({if0.almost_full, if0.almost_empty} !== 2'b01) $display("FAIL mid_flags got %b exp 01", {if0.almost_full, if0.almost_empty}); else passed++;
    total++; if ({if0.overflow, if0.underflow} !== 2'b00) $display("FAIL mid_err got %b exp 00", {if0.overflow, if0.underflow}); else passed++;
    #2;
    reset = 1'b1;
    push0(1, 32'h42, 32'h0);
    if0.rd_ready = 1'b1;
    step();
    if0.rd_ready = 1'b0;
    exp_d = sb0.pop_front();
    total++; if (if0.rd_data !== exp_d || if0.rd_valid !== 1'b1) $display("FAIL mid_post got %h/%b exp %h/1", if0.rd_data, if0.rd_valid, exp_d); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    if0.wr_valid = 1'b0; if0.wr_data = '0; if0.rd_ready = 1'b0;
    if1.wr_valid = 1'b0; if1.wr_data = '0; if1.rd_ready = 1'b0;
    #12;
    reset = 1'b1;
    step();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_fwft();
    test_back_to_back();
    test_underflow();
    clear0 = 1'b1;
    step();
    clear0 = 1'b0;
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
